// File: rtl/x_buf_loader_pkg.sv
// Shared definitions for the X buffer loader and the read-address generators:
// FSM state encoding and default geometry of the X buffer.
package x_buf_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_CELL   = 53;
  localparam int DEF_NUM_INPUT  = 53;
  localparam int DEF_TIMESTEP   = 7;

  // Width of a counter that must hold values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/x_buf_row_cnt.sv
// Column / row / row-base counter for the X buffer write side.
// addr = base + col, where base steps by NUM_CELL per row. ROW_LAST is the
// last column of a row: NUM_INPUT-1 normally, NUM_CELL-1 when rows are padded.
module x_buf_row_cnt
  import x_buf_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_CELL   = DEF_NUM_CELL,
  parameter int NUM_INPUT  = DEF_NUM_INPUT,
  parameter int TIMESTEP   = DEF_TIMESTEP,
  parameter int ROW_LAST   = DEF_NUM_INPUT - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_end,
  output logic                  row_end,
  output logic                  seq_end
);

  localparam int COL_W = cnt_width(NUM_CELL);
  localparam int ROW_W = cnt_width(TIMESTEP);

  logic [COL_W-1:0]      col_reg;
  logic [ROW_W-1:0]      row_reg;
  logic [ADDR_WIDTH-1:0] base_reg;

  assign in_end  = (col_reg == COL_W'(NUM_INPUT - 1));
  assign row_end = (col_reg == COL_W'(ROW_LAST));
  assign seq_end = row_end && (row_reg == ROW_W'(TIMESTEP - 1));
  assign addr    = base_reg + ADDR_WIDTH'(col_reg);

  // Clear on a new load, otherwise step column and wrap into the next row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg  <= '0;
      row_reg  <= '0;
      base_reg <= '0;
    end else if (clear) begin
      col_reg  <= '0;
      row_reg  <= '0;
      base_reg <= '0;
    end else if (advance) begin
      if (row_end) begin
        col_reg  <= '0;
        row_reg  <= row_reg + ROW_W'(1);
        base_reg <= base_reg + ADDR_WIDTH'(NUM_CELL);
      end else begin
        col_reg <= col_reg + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/x_buf_loader.sv
// X buffer loader: takes the input sequence as a valid/ready stream and writes
// element i of timestep t to X RAM address t*NUM_CELL + i, one cycle after
// acceptance. o_done stays high from the final write until the next start.
// Optional feature: define X_BUF_ZERO_PAD_EN to zero-fill the gap addresses
// base+NUM_INPUT .. base+NUM_CELL-1 of every row (PAD state).
module x_buf_loader
  import x_buf_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CELL   = DEF_NUM_CELL,
  parameter int NUM_INPUT  = DEF_NUM_INPUT,
  parameter int TIMESTEP   = DEF_TIMESTEP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done
);

`ifdef X_BUF_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  // Padding only exists when there is a gap between the inputs and the stride.
  localparam bit PAD_ACTIVE = PAD_EN && (NUM_INPUT < NUM_CELL);
  localparam int ROW_LAST   = PAD_ACTIVE ? NUM_CELL - 1 : NUM_INPUT - 1;

  state_t state_reg, state_next;

  logic                  xfer;
  logic                  pad_wr;
  logic                  wr_fire;
  logic                  cnt_clear;
  logic                  to_pad;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic                  in_end;
  logic                  row_end;
  logic                  seq_end;

  logic                  wr_en_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;

  assign o_ready   = (state_reg == ST_LOAD);
  assign o_busy    = (state_reg == ST_LOAD) || (state_reg == ST_PAD);
  assign o_done    = (state_reg == ST_DONE);
  assign xfer      = i_valid && o_ready;
`ifdef X_BUF_ZERO_PAD_EN
  assign pad_wr    = (state_reg == ST_PAD);
`else
  assign pad_wr    = 1'b0;
`endif
  assign wr_fire   = xfer || pad_wr;
  assign cnt_clear = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign to_pad    = PAD_ACTIVE && in_end && !row_end;

  assign o_wr_en   = wr_en_reg;
  assign o_wr_addr = wr_addr_reg;
  assign o_wr_data = wr_data_reg;

  x_buf_row_cnt #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_CELL   (NUM_CELL),
    .NUM_INPUT  (NUM_INPUT),
    .TIMESTEP   (TIMESTEP),
    .ROW_LAST   (ROW_LAST)
  ) u_row_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .advance (wr_fire),
    .addr    (cnt_addr),
    .in_end  (in_end),
    .row_end (row_end),
    .seq_end (seq_end)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; start is only honoured outside a load.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (xfer) begin
          if (seq_end)     state_next = ST_DONE;
          else if (to_pad) state_next = ST_PAD;
        end
      end
`ifdef X_BUF_ZERO_PAD_EN
      ST_PAD: begin
        if (row_end) state_next = seq_end ? ST_DONE : ST_LOAD;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Write register: one-cycle write latency; address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= wr_fire;
      if (wr_fire) begin
        wr_addr_reg <= cnt_addr;
        wr_data_reg <= pad_wr ? '0 : i_data;
      end
    end
  end

endmodule

// File: tb/tb_x_buf_loader.sv
// Directed testbench for x_buf_loader: a default-geometry instance (a_*) and a
// small-geometry instance (b_*, NUM_CELL=8, NUM_INPUT=5, TIMESTEP=3).
module tb_x_buf_loader;

  localparam int AW = 12;
  localparam int DW = 16;
`ifdef X_BUF_ZERO_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_start, a_valid, a_ready, a_wr_en, a_busy, a_done;
  logic [DW-1:0] a_data, a_wr_data;
  logic [AW-1:0] a_wr_addr;
  logic          b_start, b_valid, b_ready, b_wr_en, b_busy, b_done;
  logic [DW-1:0] b_data, b_wr_data;
  logic [AW-1:0] b_wr_addr;

  int checks = 0;
  int failures = 0;
  logic sel = 1'b0;

  logic          m_ready, m_wr_en, m_busy, m_done;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  assign m_ready   = sel ? b_ready   : a_ready;
  assign m_wr_en   = sel ? b_wr_en   : a_wr_en;
  assign m_busy    = sel ? b_busy    : a_busy;
  assign m_done    = sel ? b_done    : a_done;
  assign m_wr_addr = sel ? b_wr_addr : a_wr_addr;
  assign m_wr_data = sel ? b_wr_data : a_wr_data;

  x_buf_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CELL(53), .NUM_INPUT(53), .TIMESTEP(7)
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .i_valid(a_valid), .i_data(a_data),
    .o_ready(a_ready), .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr),
    .o_wr_data(a_wr_data), .o_busy(a_busy), .o_done(a_done)
  );

  x_buf_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CELL(8), .NUM_INPUT(5), .TIMESTEP(3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .i_valid(b_valid), .i_data(b_data),
    .o_ready(b_ready), .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr),
    .o_wr_data(b_wr_data), .o_busy(b_busy), .o_done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dpat(input int k);
    return 16'(k * 37 + 'h1234);
  endfunction

  task automatic drv(input logic s, input logic v, input logic [15:0] d);
    if (sel) begin
      b_start = s; b_valid = v; b_data = d;
      a_start = 1'b0; a_valid = 1'b0; a_data = '0;
    end else begin
      a_start = s; a_valid = v; a_data = d;
      b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full (or aborted) load on the selected instance. Expected addresses
  // and data are built from the geometry: t*nc+i, stimulus pattern or zero pad.
  task automatic run_load(input int nc, input int ni, input int ts, input bit pad,
                          input bit rnd, input int stop_at, input int start_at);
    int rowlen, total, k, e, bubbles, ea;
    bit v, last, is_pad;
    logic [15:0] ed;
    rowlen = pad ? nc : ni;
    total  = ts * rowlen;
    k = 0;
    e = 0;
    drv(1'b1, 1'b0, 16'h0);
    tick();
    drv(1'b0, 1'b0, 16'h0);
    chk("start_busy", m_busy, 1);
    chk("start_done", m_done, 0);
    for (int t = 0; t < ts; t++) begin
      for (int i = 0; i < rowlen; i++) begin
        is_pad = (i >= ni);
        ea     = t * nc + i;
        ed     = is_pad ? 16'h0 : dpat(k);
        last   = (e == total - 1);
        if (is_pad) begin
          chk("pad_ready", m_ready, 0);
          drv(e == start_at, 1'b1, 16'hBEEF);
          tick();
        end else begin
          bubbles = 0;
          do begin
            chk("load_ready", m_ready, 1);
            v = !rnd || (bubbles >= 8) || ($urandom_range(0, 1) == 1);
            drv(e == start_at, v, v ? dpat(k) : 16'hDEAD);
            tick();
            if (!v) begin
              chk("bubble_wr_en", m_wr_en, 0);
              bubbles++;
            end
          end while (!v);
        end
        chk("wr_en", m_wr_en, 1);
        chk("wr_addr", m_wr_addr, ea);
        chk("wr_data", m_wr_data, ed);
        chk("done", m_done, last);
        chk("busy", m_busy, !last);
        if (!is_pad) k++;
        e++;
        if (stop_at > 0 && k == stop_at && !is_pad) begin
          rst = 1'b0;
          #1;
          chk("rst_wr_en", m_wr_en, 0);
          chk("rst_busy", m_busy, 0);
          chk("rst_ready", m_ready, 0);
          drv(1'b0, 1'b0, 16'h0);
          tick();
          rst = 1'b1;
          return;
        end
      end
    end
    drv(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    rst = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_data = '0;
    b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      chk("reset_ready", m_ready, 0);
      chk("reset_wr_en", m_wr_en, 0);
      chk("reset_addr", m_wr_addr, 0);
      chk("reset_data", m_wr_data, 0);
      chk("reset_busy", m_busy, 0);
      chk("reset_done", m_done, 0);
    end
    rst = 1'b1;
    tick();

    // Default geometry, valid held high: 371 back-to-back writes.
    sel = 1'b0;
    run_load(53, 53, 7, 1'b0, 1'b0, -1, -1);
    tick();
    chk("a_hold_wr_en", m_wr_en, 0);
    chk("a_hold_addr", m_wr_addr, 370);
    chk("a_hold_done", m_done, 1);

    // Small geometry: gaps skipped, or zero-filled when padding is built in.
    sel = 1'b1;
    run_load(8, 5, 3, PAD_ON, 1'b0, -1, -1);
    tick();
    chk("b_hold_wr_en", m_wr_en, 0);
    chk("b_hold_addr", m_wr_addr, PAD_ON ? 23 : 20);
    chk("b_hold_done", m_done, 1);

    // Restart from DONE with random bubbles and a stray start mid-load.
    sel = 1'b0;
    run_load(53, 53, 7, 1'b0, 1'b1, -1, 200);

    // Reset after 100 transfers, then a fresh load must start at address 0.
    run_load(53, 53, 7, 1'b0, 1'b0, 100, -1);
    chk("post_rst_done", m_done, 0);
    run_load(53, 53, 7, 1'b0, 1'b0, -1, 5);

    // Small geometry from IDLE with random bubbles and a start during load.
    sel = 1'b1;
    run_load(8, 5, 3, PAD_ON, 1'b1, -1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
